// File: rtl/det_count_display.sv
// Two-digit BCD event counter fed by a registered detect flag, driving one
// active-high 7-segment digit (units or tens) with a retriggerable dp pulse.
module det_count_display #(
   parameter int unsigned DP_HOLD = 4,
   parameter int unsigned TW      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       det_in,
   input  logic       clr,
   input  logic       disp_sel,
   output logic [7:0] seg,
   output logic [7:0] bcd,
   output logic       ovf
);

   logic          det_q, det_d;
   logic [3:0]    units_q, units_d;
   logic [3:0]    tens_q, tens_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    seg_q, seg_d;
   logic          rise;
   logic [3:0]    shown;

   function automatic logic [6:0] font(input logic [3:0] digit);
      logic [6:0] f;
      case (digit)
         4'd0:    f = 7'h3F;
         4'd1:    f = 7'h06;
         4'd2:    f = 7'h5B;
         4'd3:    f = 7'h4F;
         4'd4:    f = 7'h66;
         4'd5:    f = 7'h6D;
         4'd6:    f = 7'h7D;
         4'd7:    f = 7'h07;
         4'd8:    f = 7'h7F;
         4'd9:    f = 7'h6F;
         default: f = 7'h40;
      endcase
      return f;
   endfunction

   assign rise  = det_in & ~det_q;
   assign shown = disp_sel ? tens_q : units_q;

   always_comb begin
      det_d   = det_q;
      units_d = units_q;
      tens_d  = tens_q;
      timer_d = timer_q;
      ovf_d   = ovf_q;
      seg_d   = seg_q;
      if (ena) begin
         det_d = det_in;
         // Display reflects the state before this edge, hence one cycle behind bcd.
         seg_d = {timer_q != '0, font(shown)};
         if (clr) begin
            units_d = '0;
            tens_d  = '0;
            timer_d = '0;
            ovf_d   = 1'b0;
         end else if (rise) begin
            timer_d = TW'(DP_HOLD);
            if (units_q == 4'd9) begin
               units_d = '0;
               if (tens_q == 4'd9) begin
                  tens_d = '0;
                  ovf_d  = 1'b1;
               end else begin
                  tens_d = tens_q + 4'd1;
               end
            end else begin
               units_d = units_q + 4'd1;
            end
         end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         det_q   <= 1'b0;
         units_q <= '0;
         tens_q  <= '0;
         timer_q <= '0;
         ovf_q   <= 1'b0;
         seg_q   <= 8'h3F;
      end else begin
         det_q   <= det_d;
         units_q <= units_d;
         tens_q  <= tens_d;
         timer_q <= timer_d;
         ovf_q   <= ovf_d;
         seg_q   <= seg_d;
      end
   end

   assign seg = seg_q;
   assign bcd = {tens_q, units_q};
   assign ovf = ovf_q;

endmodule

// File: tb/tb_det_count_display.sv
// Bench for det_count_display: integer-level reference model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_det_count_display;

   localparam int unsigned DP_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic       det_in = 1'b0;
   logic       clr = 1'b0;
   logic       disp_sel = 1'b0;
   logic [7:0] seg;
   logic [7:0] bcd;
   logic       ovf;

   int checks = 0;
   int failures = 0;

   det_count_display #(
      .DP_HOLD(DP_HOLD),
      .TW     (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .det_in  (det_in),
      .clr     (clr),
      .disp_sel(disp_sel),
      .seg     (seg),
      .bcd     (bcd),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] digit_font(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return tbl[d];
   endfunction

   // Reference model: count as an integer 0..99, dp hold as a countdown.
   int         m_cnt = 0;
   int         m_hold = 0;
   bit         m_ovf = 0;
   bit         m_prev = 0;
   logic [7:0] m_seg = 8'h3F;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  = 0;
         m_hold = 0;
         m_ovf  = 0;
         m_prev = 0;
         m_seg  = 8'h3F;
      end else if (ena) begin
         m_seg = {m_hold > 0, digit_font(disp_sel ? m_cnt / 10 : m_cnt % 10)};
         if (clr) begin
            m_cnt  = 0;
            m_hold = 0;
            m_ovf  = 0;
         end else if (det_in && !m_prev) begin
            if (m_cnt == 99) m_ovf = 1;
            m_cnt  = (m_cnt + 1) % 100;
            m_hold = DP_HOLD;
         end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
         end
         m_prev = det_in;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_bcd", bcd, 8'(((m_cnt / 10) << 4) | (m_cnt % 10)));
      chk("model_seg", seg, m_seg);
      chk("model_ovf", {7'd0, ovf}, {7'd0, m_ovf});
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ena = 1'b1;
      det_in = 1'b0;
      clr = 1'b0;
      disp_sel = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic pulse();
      det_in = 1'b1;
      tick();
      det_in = 1'b0;
      tick();
   endtask

   initial begin
      #1;
      do_reset();

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_bcd", bcd, 8'h00);
         chk("idle_seg", seg, 8'h3F);
      end
      chk("idle_ovf", {7'd0, ovf}, 8'h00);

      // Single pulse: dp lit for four display cycles
      det_in = 1'b1;
      tick();
      chk("pulse_bcd", bcd, 8'h01);
      det_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("pulse_seg_dp", seg, 8'h86);
      end
      tick();
      chk("pulse_seg_nodp", seg, 8'h06);

      // Held level counts once
      do_reset();
      det_in = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("held_bcd", bcd, 8'h01);
      det_in = 1'b0;
      tick();
      pulse();
      chk("second_bcd", bcd, 8'h02);

      // Full wrap with tens display at 37
      do_reset();
      for (int p = 1; p <= 101; p++) begin
         pulse();
         if (p == 10) chk("bcd_10", bcd, 8'h10);
         if (p == 37) begin
            disp_sel = 1'b1;
            tick();
            chk("tens_37", seg & 8'h7F, 8'h4F);
            disp_sel = 1'b0;
         end
         if (p == 99) begin
            chk("bcd_99", bcd, 8'h99);
            chk("ovf_99", {7'd0, ovf}, 8'h00);
         end
         if (p == 100) begin
            chk("bcd_wrap", bcd, 8'h00);
            chk("ovf_wrap", {7'd0, ovf}, 8'h01);
         end
      end
      chk("bcd_101", bcd, 8'h01);
      chk("ovf_sticky", {7'd0, ovf}, 8'h01);

      // clr beats a simultaneous rise
      do_reset();
      for (int p = 0; p < 42; p++) pulse();
      chk("bcd_42", bcd, 8'h42);
      det_in = 1'b1;
      clr = 1'b1;
      tick();
      chk("clr_bcd", bcd, 8'h00);
      chk("clr_ovf", {7'd0, ovf}, 8'h00);
      clr = 1'b0;
      tick();
      chk("clr_seg", seg, 8'h3F);
      for (int i = 0; i < 3; i++) tick();
      chk("clr_held_bcd", bcd, 8'h00);
      det_in = 1'b0;

      // Enable low freezes everything, including the dp countdown
      do_reset();
      pulse();
      chk("frz_seg0", seg, 8'h86);
      ena = 1'b0;
      det_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) det_in = 1'b0;
         tick();
         chk("frz_bcd", bcd, 8'h01);
         chk("frz_seg", seg, 8'h86);
      end
      ena = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("thaw_seg_dp", seg, 8'h86);
      end
      tick();
      chk("thaw_seg_nodp", seg, 8'h06);
      pulse();
      chk("two_seg", seg, 8'hDB);

      // Async reset mid dp-hold
      rst_n = 1'b0;
      #1;
      chk("arst_seg", seg, 8'h3F);
      chk("arst_bcd", bcd, 8'h00);
      @(posedge clk);
      #2;
      det_in = 1'b1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_rise", bcd, 8'h01);
      det_in = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
